// File: rtl/sqrt_req_arbiter.sv
// Round-robin arbiter sharing one CORDIC sqrt unit among N requesters.
// Ports: req_* (in/rdy), resp_* (out), sq_* (sqrt unit side), busy.
module sqrt_req_arbiter #(
  parameter int N       = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_val,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_rdy,
  output logic [N-1:0]   resp_val,
  output logic [W-1:0]   resp_data,
  output logic           resp_err,
  output logic           sq_operands_val,
  output logic [W-1:0]   sq_A,
  input  logic           sq_ready,
  input  logic [W-1:0]   sq_sqrt_x,
  input  logic           sq_sqrt_valid,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] win;
  logic [W-1:0]  win_op;
  logic [W-1:0]  op_q;
  logic [W-1:0]  res_q;
  logic          err_q;
  logic [CW-1:0] cnt;
  logic          found;
  logic          grant;
  logic          win_neg;
  logic          tmo;

  // First requesting index after the last winner, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    for (int k = 1; k <= N; k++) begin
      if (!found && req_val[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        win   = PW'((int'(ptr) + k) % N);
      end
    end
  end

  assign win_op  = req_data[int'(win)*W +: W];
  assign win_neg = win_op[W-1];
  assign grant   = (state == IDLE) && !reset
                && found && sq_ready;
  assign tmo     = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = win_neg ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (sq_sqrt_valid || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= PW'(N - 1);
      gidx  <= '0;
      op_q  <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant) begin
            ptr  <= win;
            gidx <= win;
            // Negative operands never reach the unit.
            if (win_neg) begin
              res_q <= '0;
              err_q <= 1'b1;
            end else begin
              op_q <= win_op;
            end
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + CW'(1);
          // A result arriving on the timeout cycle still wins.
          if (sq_sqrt_valid) begin
            res_q <= sq_sqrt_x;
            err_q <= 1'b0;
          end else if (tmo) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_rdy         = grant ? (N'(1) << win) : '0;
  assign resp_val        = (state == RESP) ? (N'(1) << gidx) : '0;
  assign resp_data       = res_q;
  assign resp_err        = err_q;
  assign sq_operands_val = (state == ISSUE);
  assign sq_A            = op_q;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_sqrt_req_arbiter.sv
// Bench for sqrt_req_arbiter: directed scenarios plus random traffic
// checked against a transaction-timing reference model.
module tb_sqrt_req_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_val = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_rdy;
  logic [N-1:0]   resp_val;
  logic [W-1:0]   resp_data;
  logic           resp_err;
  logic           sq_operands_val;
  logic [W-1:0]   sq_A;
  logic           sq_ready = 1'b1;
  logic [W-1:0]   sq_sqrt_x = '0;
  logic           sq_sqrt_valid = 1'b0;
  logic           busy;

  always #5 clk = ~clk;

  sqrt_req_arbiter #(.N(N), .W(W), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_val         (req_val),
    .req_data        (req_data),
    .req_rdy         (req_rdy),
    .resp_val        (resp_val),
    .resp_data       (resp_data),
    .resp_err        (resp_err),
    .sq_operands_val (sq_operands_val),
    .sq_A            (sq_A),
    .sq_ready        (sq_ready),
    .sq_sqrt_x       (sq_sqrt_x),
    .sq_sqrt_valid   (sq_sqrt_valid),
    .busy            (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  bit         m_idle = 1'b1;
  bit         m_err;
  int         m_last = N - 1;
  int         m_owner = 0;
  int         m_issue_at = -1;
  int         m_resp_at = -1;
  int         m_wlo = -1;
  int         m_whi = -1;
  int         fire_at = -1;
  int         next_lat = 4;
  logic [W-1:0] m_op;
  logic [W-1:0] m_res;
  logic [W-1:0] stub_x = '0;
  int         gq[$];

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic cycle_check();
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_rv;
    logic [W-1:0] d;
    bit           rsp_now;
    int           w;
    rsp_now = (cyc == m_resp_at);
    e_rdy   = '0;
    e_rv    = rsp_now ? (N'(1) << m_owner) : '0;
    check_eq("busy", {31'b0, busy}, {31'b0, !m_idle});
    check_eq("opv", {31'b0, sq_operands_val},
             {31'b0, cyc == m_issue_at});
    if (cyc == m_issue_at)
      check_eq("sq_A", {16'b0, sq_A}, {16'b0, m_op});
    if (sq_operands_val) stub_x = sq_A + 1'b1;
    check_eq("resp_val", {28'b0, resp_val}, {28'b0, e_rv});
    if (rsp_now) begin
      check_eq("resp_data", {16'b0, resp_data}, {16'b0, m_res});
      check_eq("resp_err", {31'b0, resp_err}, {31'b0, m_err});
    end
    if (m_idle && !reset && |req_val && sq_ready) begin
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && req_val[(m_last + k) % N]) w = (m_last + k) % N;
      e_rdy[w] = 1'b1;
      gq.push_back(w);
      m_owner = w;
      m_last  = w;
      m_idle  = 1'b0;
      d = req_data[w*W +: W];
      fire_at = -1;
      m_wlo   = -1;
      m_whi   = -1;
      if (d[W-1]) begin
        m_res = '0;
        m_err = 1'b1;
        m_resp_at = cyc + 1;
      end else begin
        m_op = d;
        m_issue_at = cyc + 1;
        fire_at = cyc + 1 + next_lat;
        m_wlo = cyc + 2;
        if (next_lat <= TMO) begin
          m_resp_at = cyc + 2 + next_lat;
          m_res = d + 1'b1;
          m_err = 1'b0;
        end else begin
          m_resp_at = cyc + 2 + TMO;
          m_res = '0;
          m_err = 1'b1;
        end
        m_whi = m_resp_at - 1;
      end
    end
    check_eq("req_rdy", {28'b0, req_rdy}, {28'b0, e_rdy});
    if (rsp_now) m_idle = 1'b1;
  endtask

  task automatic step(input logic [N-1:0] rv,
                      input logic [N*W-1:0] rd,
                      input logic rdy,
                      input bit spur);
    @(negedge clk);
    cyc++;
    req_val  = rv;
    req_data = rd;
    sq_ready = rdy;
    if (cyc == fire_at) begin
      sq_sqrt_valid = 1'b1;
      sq_sqrt_x     = stub_x;
    end else if (spur && !(cyc >= m_wlo && cyc <= m_whi)
                 && $urandom_range(0, 5) == 0) begin
      sq_sqrt_valid = 1'b1;
      sq_sqrt_x     = W'($urandom);
    end else begin
      sq_sqrt_valid = 1'b0;
      sq_sqrt_x     = '0;
    end
    #1;
    cycle_check();
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc++;
    reset = 1'b1;
    req_val = '1;
    sq_ready = 1'b1;
    sq_sqrt_valid = 1'b0;
    @(negedge clk);
    cyc++;
    #1;
    check_eq("rst_rdy", {28'b0, req_rdy}, 32'h0);
    check_eq("rst_rv", {28'b0, resp_val}, 32'h0);
    check_eq("rst_data", {16'b0, resp_data}, 32'h0);
    check_eq("rst_err", {31'b0, resp_err}, 32'h0);
    check_eq("rst_opv", {31'b0, sq_operands_val}, 32'h0);
    check_eq("rst_sqA", {16'b0, sq_A}, 32'h0);
    check_eq("rst_busy", {31'b0, busy}, 32'h0);
    m_idle = 1'b1;
    m_last = N - 1;
    m_issue_at = -1;
    m_resp_at = -1;
    fire_at = -1;
    m_wlo = -1;
    m_whi = -1;
    gq.delete();
    reset = 1'b0;
    req_val = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [N*W-1:0] rd;
    logic [N-1:0]   rv;
    int             rr_exp[5];
    rr_exp = '{0, 1, 2, 3, 0};

    do_reset();

    // single request from requester 2
    rd = '0;
    rd[2*W +: W] = 16'h0800;
    next_lat = 10;
    step(4'b0100, rd, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) step('0, rd, 1'b1, 1'b0);

    // round robin with all requesters active
    do_reset();
    for (int i = 0; i < N; i++) rd[i*W +: W] = W'(16'h0100 * (i + 1));
    next_lat = 3;
    for (int i = 0; i < 40; i++) step('1, rd, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step('0, rd, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      check_eq("rr_order", (i < gq.size()) ? gq[i] : -1, rr_exp[i]);

    // negative operand from requester 1
    rd = '0;
    rd[1*W +: W] = 16'hFFF0;
    step(4'b0010, rd, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step('0, rd, 1'b1, 1'b0);

    // hung unit, then a late result
    rd = '0;
    rd[3*W +: W] = 16'h0123;
    next_lat = 500;
    step(4'b1000, rd, 1'b1, 1'b0);
    for (int i = 0; i < 70; i++) step('0, rd, 1'b1, 1'b1);
    fire_at = cyc + 1;
    for (int i = 0; i < 4; i++) step('0, rd, 1'b1, 1'b0);

    // sqrt unit not ready
    rd = '0;
    rd[0 +: W] = 16'h0042;
    next_lat = 5;
    for (int i = 0; i < 5; i++) step(4'b0001, rd, 1'b0, 1'b0);
    step(4'b0001, rd, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step('0, rd, 1'b1, 1'b0);

    // reset while waiting on the unit
    rd = '0;
    rd[3*W +: W] = 16'h0300;
    next_lat = 30;
    do_reset();
    step(4'b1000, rd, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step('0, rd, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < N; i++) rd[i*W +: W] = W'(16'h0010 * (i + 1));
    next_lat = 2;
    for (int i = 0; i < 10; i++) step('1, rd, 1'b1, 1'b0);
    check_eq("rst_first", (gq.size() > 0) ? gq[0] : -1, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rv = N'($urandom);
      if ($urandom_range(0, 3) == 0) rv = '0;
      for (int j = 0; j < N; j++) rd[j*W +: W] = W'($urandom);
      case ($urandom_range(0, 9))
        0:       next_lat = $urandom_range(62, 66);
        1:       next_lat = 500;
        default: next_lat = $urandom_range(1, 12);
      endcase
      step(rv, rd, ($urandom_range(0, 4) != 0), 1'b1);
    end
    for (int i = 0; i < 80; i++) step('0, rd, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
